// File: rtl/sysarray_skew_feeder.sv
// Operand-side skew feeder for the systolic array.
// Accepts unskewed weight/feature vector pairs and emits them diagonally
// skewed (lane k delayed k advances). It also sequences the stream
// (start, load, flush, done) and drives the array enable.
// Optional build macro FEEDER_STALL_CNT_EN adds a 32-bit stall_count output
// that counts LOAD cycles with in_valid low.
module sysarray_skew_feeder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SYS_DIM    = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           stream_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*SYS_DIM-1:0]  in_weight,
    input  logic [DATA_WIDTH*SYS_DIM-1:0]  in_layer,
    output logic [DATA_WIDTH*SYS_DIM-1:0]  weight_array,
    output logic [DATA_WIDTH*SYS_DIM-1:0]  layer_array,
    output logic                           array_enable,
    output logic                           busy,
    output logic                           done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_count
`endif
);

    localparam int unsigned FLUSH_LEN  = 2 * SYS_DIM - 2;
    localparam int unsigned FLUSH_LAST = (FLUSH_LEN == 0) ? 0 : FLUSH_LEN - 1;
    localparam int unsigned FCW        = $clog2(2 * SYS_DIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } feederState_t;

    feederState_t         state;
    feederState_t         nextState;
    logic                 advance;
    logic                 acceptStart;
    logic                 loadPhase;
    logic [LEN_WIDTH-1:0] lenReg;
    logic [LEN_WIDTH-1:0] loadCnt;
    logic [FCW-1:0]       flushCnt;

    assign loadPhase = (state == LOAD);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; an advance is an accepted pair in LOAD or any FLUSH cycle
    always_comb begin
        nextState   = state;
        advance     = 1'b0;
        acceptStart = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acceptStart = 1'b1;
                    nextState   = (stream_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    advance = 1'b1;
                    if ((loadCnt + LEN_WIDTH'(1)) == lenReg) begin
                        nextState = (FLUSH_LEN == 0) ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                advance = 1'b1;
                if (flushCnt == FCW'(FLUSH_LAST)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Stream length latch and load/flush counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            lenReg   <= '0;
            loadCnt  <= '0;
            flushCnt <= '0;
        end else begin
            if (acceptStart) begin
                lenReg  <= stream_len;
                loadCnt <= '0;
            end else if (loadPhase && advance) begin
                loadCnt <= loadCnt + LEN_WIDTH'(1);
            end
            if (state == FLUSH) begin
                flushCnt <= flushCnt + FCW'(1);
            end else begin
                flushCnt <= '0;
            end
        end
    end

    // Registered control outputs; done trails the DONE state by one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            array_enable <= 1'b0;
            done         <= 1'b0;
        end else begin
            in_ready     <= (nextState == LOAD);
            busy         <= (nextState == LOAD) || (nextState == FLUSH);
            array_enable <= advance;
            done         <= (state == DONE);
        end
    end

    // Per-lane shift chains: lane k holds k+1 stages, last stage drives the output
    for (genvar k = 0; k < SYS_DIM; k++) begin : gLane
        logic [DATA_WIDTH-1:0] wChain [0:k];
        logic [DATA_WIDTH-1:0] lChain [0:k];

        // Shift on advance only; zero is injected outside LOAD (flush)
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int j = 0; j <= k; j++) begin
                    wChain[j] <= '0;
                    lChain[j] <= '0;
                end
            end else if (advance) begin
                wChain[0] <= loadPhase ? in_weight[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                lChain[0] <= loadPhase ? in_layer[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= k; j++) begin
                    wChain[j] <= wChain[j-1];
                    lChain[j] <= lChain[j-1];
                end
            end
        end

        assign weight_array[k*DATA_WIDTH +: DATA_WIDTH] = wChain[k];
        assign layer_array[k*DATA_WIDTH +: DATA_WIDTH]  = lChain[k];
    end

`ifdef FEEDER_STALL_CNT_EN
    // Saturating count of LOAD cycles without valid input
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (acceptStart) begin
            stall_count <= '0;
        end else if (loadPhase && !in_valid && (stall_count != '1)) begin
            stall_count <= stall_count + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sysarray_skew_feeder.sv
// Scoreboard bench for sysarray_skew_feeder (SYS_DIM=4).
// The expected enable beats of each stream are computed from the skew rule
// (beat n, lane k = vector n-k lane k, else 0) and queued when the stream is
// issued. A negedge monitor pops and compares them on every array_enable.
module tb_sysarray_skew_feeder;

    localparam int unsigned DW        = 32;
    localparam int unsigned SD        = 4;
    localparam int unsigned LW        = 16;
    localparam int unsigned VW        = DW * SD;
    localparam int          FLUSH_LEN = 2 * SD - 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] stream_len;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_weight;
    logic [VW-1:0] in_layer;
    logic [VW-1:0] weight_array;
    logic [VW-1:0] layer_array;
    logic          array_enable;
    logic          busy;
    logic          done;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    sysarray_skew_feeder #(.DATA_WIDTH(DW), .SYS_DIM(SD), .LEN_WIDTH(LW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stream_len(stream_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_weight(in_weight),
        .in_layer(in_layer),
        .weight_array(weight_array),
        .layer_array(layer_array),
        .array_enable(array_enable),
        .busy(busy),
        .done(done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] expWQ[$];
    logic [VW-1:0] expLQ[$];
    logic [VW-1:0] lastExpW = '0;
    logic [VW-1:0] lastExpL = '0;
    logic [VW-1:0] vW[$];
    logic [VW-1:0] vL[$];

    int enCount   = 0;
    int doneCount = 0;
    int cyc       = 0;
    int lastEnCyc = -10;
    bit expectZero = 1'b0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event-missing-or-extra expected=per-model", name);
    endtask

    // Reference model: every enable beat of a stream straight from the skew rule
    task automatic pushExpected(input int len);
        logic [VW-1:0] bw;
        logic [VW-1:0] bl;
        logic [VW-1:0] tw;
        logic [VW-1:0] tl;
        for (int n = 0; n < len + FLUSH_LEN; n++) begin
            bw = '0;
            bl = '0;
            for (int k = 0; k < int'(SD); k++) begin
                if ((n - k) >= 0 && (n - k) < len) begin
                    tw = vW[n-k];
                    tl = vL[n-k];
                    bw[k*DW +: DW] = tw[k*DW +: DW];
                    bl[k*DW +: DW] = tl[k*DW +: DW];
                end
            end
            expWQ.push_back(bw);
            expLQ.push_back(bl);
        end
    endtask

    // Monitor: pop on enable, otherwise outputs must hold the last beat
    initial begin
        logic [VW-1:0] ew;
        logic [VW-1:0] el;
        forever begin
            @(negedge clk);
            cyc++;
            if (array_enable === 1'b1) begin
                enCount++;
                lastEnCyc = cyc;
                if (expWQ.size() == 0) begin
                    failNow("enable_unexpected");
                end else begin
                    ew = expWQ.pop_front();
                    el = expLQ.pop_front();
                    check("weight_beat", weight_array, ew);
                    check("layer_beat", layer_array, el);
                    lastExpW = ew;
                    lastExpL = el;
                end
            end else begin
                check("weight_hold", weight_array, lastExpW);
                check("layer_hold", layer_array, lastExpL);
            end
            if (done === 1'b1) begin
                doneCount++;
                check("done_queue_drained", VW'(expWQ.size()), '0);
                if (!expectZero) check("done_after_last_enable", VW'(cyc - lastEnCyc), VW'(1));
            end
        end
    end

    // One stream: mode 0 always valid, 1 two stalls after first vector, 2 random valid.
    // resetAt >= 0 aborts with a reset that many cycles into flush.
    task automatic runStream(input int len, input int mode, input bit directed,
                             input bit pulseStart, input int resetAt);
        logic [VW-1:0] tw;
        logic [VW-1:0] tl;
        int idx;
        int guard;
        int stalls;
        int stallsDone;
        int enBefore;
        int doneBefore;
        bit valid;
        bit seen;

        vW.delete();
        vL.delete();
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < int'(SD); k++) begin
                if (directed) begin
                    tw[k*DW +: DW] = DW'(i + 1 + 10 * k);
                    tl[k*DW +: DW] = DW'(1000 + i + 1 + 10 * k);
                end else begin
                    tw[k*DW +: DW] = $urandom();
                    tl[k*DW +: DW] = $urandom();
                end
            end
            vW.push_back(tw);
            vL.push_back(tl);
        end
        if (len > 0) pushExpected(len);
        expectZero = (len == 0);
        enBefore   = enCount;
        doneBefore = doneCount;

        start      = 1'b1;
        stream_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;

        if (len == 0) begin
            check("zero_done_early", VW'(done), '0);
            check("zero_busy_c1", VW'(busy), '0);
            check("zero_ready_c1", VW'(in_ready), '0);
            @(posedge clk); #1;
            check("zero_done_pulse", VW'(done), VW'(1));
            check("zero_busy_c2", VW'(busy), '0);
            check("zero_ready_c2", VW'(in_ready), '0);
        end else begin
            idx = 0;
            guard = 0;
            stalls = 0;
            stallsDone = 0;
            while (idx < len && guard < 1000) begin
                case (mode)
                    1: begin
                        valid = !(idx == 1 && stallsDone < 2);
                        if (!valid) stallsDone++;
                    end
                    2: valid = ($urandom_range(0, 3) != 0);
                    default: valid = 1'b1;
                endcase
                in_valid  = valid;
                in_weight = valid ? vW[idx] : {$urandom(), $urandom(), $urandom(), $urandom()};
                in_layer  = valid ? vL[idx] : {$urandom(), $urandom(), $urandom(), $urandom()};
                if (pulseStart && idx == 1) begin
                    start      = 1'b1;
                    stream_len = LW'(5);
                end else begin
                    start = 1'b0;
                end
                seen = (in_ready === 1'b1);
                if (seen && !valid) stalls++;
                @(posedge clk); #1;
                if (seen && valid) idx++;
                guard++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            if (idx < len) failNow("load_timeout");

            if (resetAt >= 0) begin
                repeat (resetAt) begin
                    @(posedge clk); #1;
                end
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                expWQ.delete();
                expLQ.delete();
                lastExpW = '0;
                lastExpL = '0;
                check("rst_weight", weight_array, '0);
                check("rst_layer", layer_array, '0);
                check("rst_enable", VW'(array_enable), '0);
                check("rst_ready", VW'(in_ready), '0);
                check("rst_busy", VW'(busy), '0);
                repeat (12) begin
                    @(posedge clk); #1;
                end
                check("rst_no_done", VW'(doneCount - doneBefore), '0);
                check("rst_idle_busy", VW'(busy), '0);
                return;
            end

            guard = 0;
            while (done !== 1'b1 && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (done !== 1'b1) failNow("done_timeout");
`ifdef FEEDER_STALL_CNT_EN
            check("stall_count", VW'(stall_count), VW'(stalls));
`endif
        end

        @(posedge clk); #1;
        check("done_single_pulse", VW'(done), '0);
        check("done_count", VW'(doneCount - doneBefore), VW'(1));
        check("enable_total", VW'(enCount - enBefore), VW'((len == 0) ? 0 : len + FLUSH_LEN));
        check("busy_after_done", VW'(busy), '0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        stream_len = '0;
        in_valid   = 1'b0;
        in_weight  = '0;
        in_layer   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_weight", weight_array, '0);
        check("reset_layer", layer_array, '0);
        check("reset_enable", VW'(array_enable), '0);
        check("reset_ready", VW'(in_ready), '0);
        check("reset_busy", VW'(busy), '0);
        check("reset_done", VW'(done), '0);
        rst = 1'b1;
        @(posedge clk); #1;

        runStream(3, 0, 1'b1, 1'b0, -1);   // basic skew
        runStream(3, 1, 1'b1, 1'b0, -1);   // two-cycle stall
        runStream(0, 0, 1'b1, 1'b0, -1);   // zero length
        runStream(3, 0, 1'b1, 1'b1, -1);   // start ignored during LOAD
        runStream(3, 0, 1'b1, 1'b0, 2);    // reset during flush
        runStream(2, 0, 1'b1, 1'b0, -1);   // clean restart
        runStream(3, 2, 1'b0, 1'b0, -1);   // back-to-back pair
        runStream(4, 0, 1'b0, 1'b0, -1);
        for (int s = 0; s < 6; s++) begin
            runStream(int'($urandom_range(1, 7)), 2, 1'b0, 1'b0, -1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
